mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 115 +++++++++++
 tb/tb_mdu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and fixed-latency long operations.
// Optional multiply-accumulate ops (codes 9-12) are enabled by defining MDU_MADD_EN.
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_RD
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif
    localparam logic [3:0] LAT_MUL  = 4'd5;
    localparam logic [3:0] LAT_DIV  = 4'd10;

    logic [31:0] hi_reg, hi_next, lo_reg, lo_next;
    logic [63:0] pending_reg, pending_next;
    logic [3:0]  count_reg, count_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes: quotient truncates toward zero, remainder follows dividend sign.
    assign a_mag = A[31] ? (32'd0 - A) : A;
    assign b_mag = B[31] ? (32'd0 - B) : B;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign q_s   = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = A[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = (B == 32'd0) ? 32'd0 : A / B;
    assign r_u   = (B == 32'd0) ? 32'd0 : A % B;

    always_comb begin
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pending_next = pending_reg;
        count_next   = count_reg;
        if (count_reg != 4'd0) begin
            count_next = count_reg - 4'd1;
            if (count_reg == 4'd1) begin
                hi_next = pending_reg[63:32];
                lo_next = pending_reg[31:0];
            end
        end else if (Start) begin
            case (MDUOp)
                OP_MULT:  begin pending_next = prod_s; count_next = LAT_MUL; end
                OP_MULTU: begin pending_next = prod_u; count_next = LAT_MUL; end
                // A zero divisor re-commits the current HI/LO, so completion leaves them unchanged.
                OP_DIV: begin
                    pending_next = (B == 32'd0) ? {hi_reg, lo_reg} : {r_s, q_s};
                    count_next   = LAT_DIV;
                end
                OP_DIVU: begin
                    pending_next = (B == 32'd0) ? {hi_reg, lo_reg} : {r_u, q_u};
                    count_next   = LAT_DIV;
                end
                OP_MTHI: hi_next = A;
                OP_MTLO: lo_next = A;
`ifdef MDU_MADD_EN
                OP_MADD:  begin pending_next = {hi_reg, lo_reg} + prod_s; count_next = LAT_MUL; end
                OP_MADDU: begin pending_next = {hi_reg, lo_reg} + prod_u; count_next = LAT_MUL; end
                OP_MSUB:  begin pending_next = {hi_reg, lo_reg} - prod_s; count_next = LAT_MUL; end
                OP_MSUBU: begin pending_next = {hi_reg, lo_reg} - prod_u; count_next = LAT_MUL; end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pending_reg <= 64'd0;
            count_reg   <= 4'd0;
        end else begin
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pending_reg <= pending_next;
            count_reg   <= count_next;
        end
    end

    assign Busy = (count_reg != 4'd0);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    always_comb begin
        MDU_RD = 32'd0;
        case (MDUOp)
            OP_MFHI: MDU_RD = hi_reg;
            OP_MFLO: MDU_RD = lo_reg;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: cycle-level model of HI/LO/Busy plus directed literal checks.
// Define MDU_MADD_EN for both bench and RTL to exercise the multiply-accumulate ops.
module tb_mdu;
    logic        clk, rst, Start, Busy;
    logic [31:0] A, B, HI, LO, MDU_RD;
    logic [3:0]  MDUOp;

    int checks = 0;
    int errors = 0;

    // Model state: completion is tracked as an absolute edge index.
    logic [31:0] m_hi = 0, m_lo = 0, m_pend_hi = 0, m_pend_lo = 0;
    bit          m_pend_valid = 0;
    int          m_cyc = 0, m_finish = 0;
    bit          chk_en = 0;

    mdu dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
        .Busy(Busy), .HI(HI), .LO(LO), .MDU_RD(MDU_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic st, input logic r);
        logic [63:0] ps, pu, res;
        int sa, sb, lat;
        bit busy_before, is_long;
        m_cyc++;
        if (r) begin
            m_hi = 0; m_lo = 0; m_finish = 0; m_pend_valid = 0;
            return;
        end
        busy_before = (m_cyc - 1) < m_finish;
        if (m_cyc == m_finish) begin
            if (m_pend_valid) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        end else if (!busy_before && st) begin
            ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            pu = {32'd0, a} * {32'd0, b};
            sa = a; sb = b;
            res = '0; lat = 5; is_long = 1; m_pend_valid = 1;
            case (op)
                4'd1: res = ps;
                4'd2: res = pu;
                4'd3: begin lat = 10; if (b == 0) m_pend_valid = 0; else res = {sa % sb, sa / sb}; end
                4'd4: begin lat = 10; if (b == 0) m_pend_valid = 0; else res = {a % b, a / b}; end
                4'd7: begin m_hi = a; is_long = 0; end
                4'd8: begin m_lo = a; is_long = 0; end
`ifdef MDU_MADD_EN
                4'd9:  res = {m_hi, m_lo} + ps;
                4'd10: res = {m_hi, m_lo} + pu;
                4'd11: res = {m_hi, m_lo} - ps;
                4'd12: res = {m_hi, m_lo} - pu;
`endif
                default: is_long = 0;
            endcase
            if (is_long) begin
                m_finish = m_cyc + lat;
                {m_pend_hi, m_pend_lo} = res;
            end
        end
    endtask

    // Single compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, Busy}, {31'd0, (m_cyc < m_finish)});
            chk("hi", HI, m_hi);
            chk("lo", LO, m_lo);
            chk("mdu_rd", MDU_RD, (MDUOp == 4'd5) ? m_hi : (MDUOp == 4'd6) ? m_lo : 32'd0);
        end
    end

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic st, input logic r);
        MDUOp = op; A = a; B = b; Start = st; rst = r;
        if (st && !r) $display("txn t=%0t op=%0d A=%h B=%h busy=%0b", $time, op, a, b, Busy);
        @(posedge clk);
        model_edge(op, a, b, st, r);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy !== 1'b0 && n < 30) begin
            step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        MDUOp = 0; A = 0; B = 0; Start = 0; rst = 1;
        @(negedge clk); #1;
        step(4'd0, 0, 0, 1'b0, 1'b1);
        step(4'd0, 0, 0, 1'b0, 1'b1);
        chk_en = 1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);

        step(4'd8, 32'd7, 0, 1'b1, 1'b0);
        chk("mtlo_lo", LO, 32'd7);
        chk("mtlo_busy", {31'd0, Busy}, 32'd0);
        MDUOp = 4'd6; Start = 1'b0; #1;
        chk("mflo_rd", MDU_RD, 32'd7);
        step(4'd6, 0, 0, 1'b1, 1'b0);

        step(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        wait_idle(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFE);

        step(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        wait_idle(n);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        wait_idle(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        step(4'd4, 32'd7, 32'd0, 1'b1, 1'b0);
        wait_idle(n);
        chk("divu0_cycles", n, 32'd10);
        chk("divu0_hi", HI, 32'hFFFFFFFF);
        chk("divu0_lo", LO, 32'hFFFFFFFD);

        step(4'd3, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
        wait_idle(n);
        chk("div_neg_lo", LO, 32'hFFFFFFFD);
        chk("div_neg_hi", HI, 32'h00000001);
        MDUOp = 4'd5; #1;
        chk("mfhi_rd", MDU_RD, 32'h00000001);

        step(4'd1, 32'h80000000, 32'd3, 1'b1, 1'b0);
        step(4'd0, 0, 0, 1'b0, 1'b0);
        step(4'd7, 32'd5, 0, 1'b1, 1'b0);
        wait_idle(n);
        chk("mthi_busy_cycles", n, 32'd3);
        chk("mult_mthi_hi", HI, 32'hFFFFFFFE);
        chk("mult_mthi_lo", LO, 32'h80000000);

        step(4'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        repeat (3) step(4'd0, 0, 0, 1'b0, 1'b0);
        step(4'd0, 0, 0, 1'b0, 1'b1);
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        repeat (12) step(4'd0, 0, 0, 1'b0, 1'b0);
        chk("rst_late_hi", HI, 32'd0);
        chk("rst_late_lo", LO, 32'd0);

        step(4'd8, 32'd9, 0, 1'b1, 1'b1);
        chk("rst_prio_lo", LO, 32'd0);

        step(4'd7, 32'd3, 0, 1'b1, 1'b0);
        step(4'd15, 32'd9, 32'd9, 1'b1, 1'b0);
        chk("undef_hi", HI, 32'd3);
        chk("undef_busy", {31'd0, Busy}, 32'd0);

        step(4'd7, 32'd0, 0, 1'b1, 1'b0);
        step(4'd8, 32'hFFFFFFFF, 0, 1'b1, 1'b0);
        step(4'd10, 32'd1, 32'd1, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
        wait_idle(n);
        chk("maddu_cycles", n, 32'd5);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
`else
        chk("maddu_off_busy", {31'd0, Busy}, 32'd0);
        repeat (6) step(4'd0, 0, 0, 1'b0, 1'b0);
        chk("maddu_off_hi", HI, 32'd0);
        chk("maddu_off_lo", LO, 32'hFFFFFFFF);
`endif

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
